dmem_arbiter: RTL

- Two-port round-robin arbiter and sequencer in front of the single-ported, byte-addressed, 32-byte Data_Memory.
- Port 0 is the CPU load/store stage. Port 1 is the test/debug loader used to preload and inspect memory.
- The block serialises requests, drives the memory write/read strobes for exactly one cycle per transaction, and returns a registered response with error flagging.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 29 ++
 rtl/dmem_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, memory size
// defaults and the request legality check.
package dmem_pkg;

    localparam int MEM_BYTES_DEF = 32;
    localparam int ADDR_W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Misaligned or beyond the last full word; the address is widened to 64 bits
    // so the unsigned compare stays exact for any ADDR_W up to 64.
    function automatic logic addr_err(input logic [63:0] addr, input int unsigned mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > (64'(mem_bytes) - 64'd4));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker; on contention the port not granted last wins.
module rr_arb2 (
    input  logic       clk_i,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last;

    // NOTE: every output of a combinational block gets a default first, otherwise
    // an unassigned path infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
            else              gnt = req;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset)     last <= 1'b1;
        else if (|gnt) last <= gnt[1];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-ported data memory:
// grant in IDLE, one-cycle memory strobe in ACCESS, one-cycle response in RESP.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [31:0]       wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [31:0]       rdata0_o,
    output logic              err0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [31:0]       wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [31:0]       rdata1_o,
    output logic              err1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              busy_o
);

    state_t            state;
    logic [1:0]        gnt;
    logic              owner;
    logic              lat_we;
    logic              lat_err;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [31:0]       win_wdata;
    logic              win_err;
    logic [31:0]       resp_data;

    // Reset gates the enable so a request coinciding with reset is never granted.
    rr_arb2 u_arb (
        .clk_i (clk_i),
        .reset (reset),
        .req   ({req1_i, req0_i}),
        .en    ((state == ST_IDLE) && !reset),
        .gnt   (gnt)
    );

    assign gnt0_o = gnt[0];
    assign gnt1_o = gnt[1];
    assign busy_o = (state != ST_IDLE);

    always_comb begin
        win_we    = gnt[1] ? we1_i    : we0_i;
        win_addr  = gnt[1] ? addr1_i  : addr0_i;
        win_wdata = gnt[1] ? wdata1_i : wdata0_i;
        win_err   = addr_err(64'(win_addr), MEM_BYTES);
        resp_data = (lat_we || lat_err) ? 32'd0 : mem_rdata_i;
    end

    // Strobes are registered on the grant edge so they are high for the whole
    // ACCESS cycle, and an async reset in ACCESS drops them before the commit edge.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            lat_err     <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_we_o    <= 1'b0;
            mem_re_o    <= 1'b0;
            rvalid0_o   <= 1'b0;
            rdata0_o    <= '0;
            err0_o      <= 1'b0;
            rvalid1_o   <= 1'b0;
            rdata1_o    <= '0;
            err1_o      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner       <= gnt[1];
                        lat_we      <= win_we;
                        lat_err     <= win_err;
                        mem_addr_o  <= win_addr;
                        mem_wdata_o <= win_wdata;
                        mem_we_o    <= win_we && !win_err;
                        mem_re_o    <= !win_we && !win_err;
                        state       <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_we_o <= 1'b0;
                    mem_re_o <= 1'b0;
                    if (owner) begin
                        rvalid1_o <= 1'b1;
                        rdata1_o  <= resp_data;
                        err1_o    <= lat_err;
                    end else begin
                        rvalid0_o <= 1'b1;
                        rdata0_o  <= resp_data;
                        err0_o    <= lat_err;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    rvalid0_o <= 1'b0;
                    rvalid1_o <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
